// File: rtl/tl_pkg.sv
// TileLink-UH type definitions and helpers shared by the RAM responder.
package tl_pkg;

  typedef enum logic [2:0] {
    TL_A_PUT_FULL      = 3'd0,
    TL_A_PUT_PARTIAL   = 3'd1,
    TL_A_ARITHMETIC    = 3'd2,
    TL_A_LOGICAL       = 3'd3,
    TL_A_GET           = 3'd4,
    TL_A_HINT          = 3'd5,
    TL_A_ACQUIRE_BLOCK = 3'd6,
    TL_A_ACQUIRE_PERM  = 3'd7
  } tl_a_opcode_e;

  typedef enum logic [2:0] {
    TL_D_ACCESS_ACK      = 3'd0,
    TL_D_ACCESS_ACK_DATA = 3'd1
  } tl_d_opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PUT,
    ST_ACK,
    ST_GET
  } tl_state_e;

  localparam int unsigned TL_BEAT_BYTES = 8;

  // Beats in a transfer of 2^size bytes; sub-beat sizes still occupy one beat.
  function automatic logic [3:0] beats_of(input logic [3:0] size);
    case (size)
      4'd4:    return 4'd2;
      4'd5:    return 4'd4;
      4'd6:    return 4'd8;
      default: return (size < 4'd4) ? 4'd1 : 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/tl_ram_responder_mem.sv
// Beat-wide RAM: one synchronous read port, one byte-masked write port.
module tl_ram_responder_mem
  import tl_pkg::*;
#(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_re,
  input  logic [IDX_W-1:0]      i_raddr,
  output logic [DATA_W-1:0]     o_rdata,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_waddr,
  input  logic [DATA_W/8-1:0]   i_wmask,
  input  logic [DATA_W-1:0]     i_wdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Byte-masked write; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int unsigned b = 0; b < DATA_W/8; b++) begin
        if (i_wmask[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  // Read data only changes when a read is issued, so it holds while D is stalled.
  always_ff @(posedge i_clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/tl_ram_responder.sv
// TileLink-UH manager terminating A/D with a local byte-masked RAM.
module tl_ram_responder
  import tl_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 64,
  parameter int unsigned       SOURCE_W   = 1,
  parameter int unsigned       SINK_W     = 3,
  parameter int unsigned       DEPTH      = 512,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned       MAX_LGSIZE = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                auto_in_a_valid,
  output logic                auto_in_a_ready,
  input  logic [2:0]          auto_in_a_bits_opcode,
  input  logic [2:0]          auto_in_a_bits_param,
  input  logic [3:0]          auto_in_a_bits_size,
  input  logic [SOURCE_W-1:0] auto_in_a_bits_source,
  input  logic [ADDR_W-1:0]   auto_in_a_bits_address,
  input  logic [7:0]          auto_in_a_bits_mask,
  input  logic [DATA_W-1:0]   auto_in_a_bits_data,
  input  logic                auto_in_a_bits_corrupt,
  output logic                auto_in_d_valid,
  input  logic                auto_in_d_ready,
  output logic [2:0]          auto_in_d_bits_opcode,
  output logic [1:0]          auto_in_d_bits_param,
  output logic [3:0]          auto_in_d_bits_size,
  output logic [SOURCE_W-1:0] auto_in_d_bits_source,
  output logic [SINK_W-1:0]   auto_in_d_bits_sink,
  output logic                auto_in_d_bits_denied,
  output logic [DATA_W-1:0]   auto_in_d_bits_data,
  output logic                auto_in_d_bits_corrupt
);

  localparam int unsigned       IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   LIMIT = {1'b0, BASE_ADDR} + (ADDR_W+1)'(DEPTH * TL_BEAT_BYTES);

  tl_state_e           r_state, w_next;
  tl_d_opcode_e        r_d_opcode;
  logic                r_live;
  logic [3:0]          r_size;
  logic [SOURCE_W-1:0] r_source;
  logic                r_denied;
  logic [IDX_W-1:0]    r_idx;
  logic [3:0]          r_left;

  tl_a_opcode_e        w_a_op;
  logic                w_a_ready, w_d_valid, w_a_fire, w_d_fire;
  logic                w_op_get, w_op_put, w_size_ok, w_hit, w_legal;
  logic [3:0]          w_beats;
  logic [ADDR_W-1:0]   w_off;
  logic [IDX_W-1:0]    w_idx0;
  logic                w_re, w_we;
  logic [IDX_W-1:0]    w_raddr, w_waddr;
  logic [DATA_W-1:0]   w_rdata;

  assign w_a_op    = tl_a_opcode_e'(auto_in_a_bits_opcode);
  assign w_op_get  = (w_a_op == TL_A_GET);
  assign w_op_put  = (w_a_op == TL_A_PUT_FULL) || (w_a_op == TL_A_PUT_PARTIAL);
  assign w_size_ok = (auto_in_a_bits_size <= 4'(MAX_LGSIZE));
  assign w_hit     = (auto_in_a_bits_address >= BASE_ADDR) &&
                     ({1'b0, auto_in_a_bits_address} < LIMIT);
  assign w_legal   = (w_op_get || w_op_put) && w_size_ok;
  assign w_beats   = beats_of(auto_in_a_bits_size);
  assign w_off     = auto_in_a_bits_address - BASE_ADDR;
  assign w_idx0    = w_off[IDX_W+2:3];

  assign w_a_fire  = auto_in_a_valid && w_a_ready;
  assign w_d_fire  = w_d_valid && auto_in_d_ready;

  // Masks a_ready during reset and for the first cycle after release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state, handshake outputs and RAM port controls.
  always_comb begin
    w_next    = r_state;
    w_a_ready = 1'b0;
    w_d_valid = 1'b0;
    w_re      = 1'b0;
    w_raddr   = r_idx;
    w_we      = 1'b0;
    w_waddr   = r_idx;
    case (r_state)
      ST_IDLE: begin
        w_a_ready = r_live;
        if (w_a_fire) begin
          if (!w_legal) begin
            w_next = ST_ACK;
          end else if (w_op_get) begin
            w_next  = ST_GET;
            w_re    = w_hit;
            w_raddr = w_idx0;
          end else begin
            w_we    = w_hit && !auto_in_a_bits_corrupt;
            w_waddr = w_idx0;
            w_next  = (w_beats > 4'd1) ? ST_PUT : ST_ACK;
          end
        end
      end
      ST_PUT: begin
        w_a_ready = r_live;
        if (w_a_fire) begin
          w_we = !r_denied && !auto_in_a_bits_corrupt;
          if (r_left == 4'd1) w_next = ST_ACK;
        end
      end
      ST_ACK: begin
        w_d_valid = 1'b1;
        if (w_d_fire) w_next = ST_IDLE;
      end
      ST_GET: begin
        w_d_valid = 1'b1;
        if (w_d_fire) begin
          if (r_left == 4'd0) w_next = ST_IDLE;
          else                w_re   = !r_denied;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Request context: captured on the first A beat, then stepped per beat.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_d_opcode <= TL_D_ACCESS_ACK;
      r_size     <= '0;
      r_source   <= '0;
      r_denied   <= 1'b0;
      r_idx      <= '0;
      r_left     <= '0;
    end else if (r_state == ST_IDLE && w_a_fire) begin
      r_size     <= auto_in_a_bits_size;
      r_source   <= auto_in_a_bits_source;
      r_denied   <= !(w_legal && w_hit);
      r_d_opcode <= (w_a_op == TL_A_GET || w_a_op == TL_A_ARITHMETIC || w_a_op == TL_A_LOGICAL)
                    ? TL_D_ACCESS_ACK_DATA : TL_D_ACCESS_ACK;
      r_idx      <= w_idx0 + IDX_W'(1);
      r_left     <= w_beats - 4'd1;
    end else if ((r_state == ST_PUT && w_a_fire) ||
                 (r_state == ST_GET && w_d_fire && r_left != 4'd0)) begin
      r_idx      <= r_idx + IDX_W'(1);
      r_left     <= r_left - 4'd1;
    end
  end

  tl_ram_responder_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_mem (
    .i_clk   (clock),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wmask (auto_in_a_bits_mask),
    .i_wdata (auto_in_a_bits_data)
  );

  assign auto_in_a_ready        = w_a_ready;
  assign auto_in_d_valid        = w_d_valid;
  assign auto_in_d_bits_opcode  = r_d_opcode;
  assign auto_in_d_bits_param   = '0;
  assign auto_in_d_bits_size    = r_size;
  assign auto_in_d_bits_source  = r_source;
  assign auto_in_d_bits_sink    = '0;
  assign auto_in_d_bits_denied  = r_denied;
  assign auto_in_d_bits_data    = (r_state == ST_GET && !r_denied) ? w_rdata : '0;
  assign auto_in_d_bits_corrupt = (r_d_opcode == TL_D_ACCESS_ACK_DATA) && r_denied;

endmodule

// File: tb/tb_tl_ram_responder.sv
// Randomized self-checking bench for tl_ram_responder with a reference memory model.
module tb_tl_ram_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned DEPTH = 512;

  logic        clock, reset;
  logic        auto_in_a_valid, auto_in_a_ready;
  logic [2:0]  auto_in_a_bits_opcode, auto_in_a_bits_param;
  logic [3:0]  auto_in_a_bits_size;
  logic [0:0]  auto_in_a_bits_source;
  logic [31:0] auto_in_a_bits_address;
  logic [7:0]  auto_in_a_bits_mask;
  logic [63:0] auto_in_a_bits_data;
  logic        auto_in_a_bits_corrupt;
  logic        auto_in_d_valid, auto_in_d_ready;
  logic [2:0]  auto_in_d_bits_opcode;
  logic [1:0]  auto_in_d_bits_param;
  logic [3:0]  auto_in_d_bits_size;
  logic [0:0]  auto_in_d_bits_source;
  logic [2:0]  auto_in_d_bits_sink;
  logic        auto_in_d_bits_denied;
  logic [63:0] auto_in_d_bits_data;
  logic        auto_in_d_bits_corrupt;

  tl_ram_responder #(
    .ADDR_W     (32),
    .DATA_W     (64),
    .SOURCE_W   (1),
    .SINK_W     (3),
    .DEPTH      (DEPTH),
    .BASE_ADDR  (BASE),
    .MAX_LGSIZE (6)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .auto_in_a_valid        (auto_in_a_valid),
    .auto_in_a_ready        (auto_in_a_ready),
    .auto_in_a_bits_opcode  (auto_in_a_bits_opcode),
    .auto_in_a_bits_param   (auto_in_a_bits_param),
    .auto_in_a_bits_size    (auto_in_a_bits_size),
    .auto_in_a_bits_source  (auto_in_a_bits_source),
    .auto_in_a_bits_address (auto_in_a_bits_address),
    .auto_in_a_bits_mask    (auto_in_a_bits_mask),
    .auto_in_a_bits_data    (auto_in_a_bits_data),
    .auto_in_a_bits_corrupt (auto_in_a_bits_corrupt),
    .auto_in_d_valid        (auto_in_d_valid),
    .auto_in_d_ready        (auto_in_d_ready),
    .auto_in_d_bits_opcode  (auto_in_d_bits_opcode),
    .auto_in_d_bits_param   (auto_in_d_bits_param),
    .auto_in_d_bits_size    (auto_in_d_bits_size),
    .auto_in_d_bits_source  (auto_in_d_bits_source),
    .auto_in_d_bits_sink    (auto_in_d_bits_sink),
    .auto_in_d_bits_denied  (auto_in_d_bits_denied),
    .auto_in_d_bits_data    (auto_in_d_bits_data),
    .auto_in_d_bits_corrupt (auto_in_d_bits_corrupt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [63:0] model [DEPTH];
  logic [63:0] t_data [8];
  logic [7:0]  t_mask [8];
  logic        t_corrupt [8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one A beat and returns at the falling edge after it was accepted; valid is left high.
  task automatic send_a(input logic [2:0] op, input logic [3:0] size, input logic src,
                        input logic [31:0] addr, input int k);
    int n = 0;
    auto_in_a_valid        = 1'b1;
    auto_in_a_bits_opcode  = op;
    auto_in_a_bits_param   = 3'($urandom_range(0, 7));
    auto_in_a_bits_size    = size;
    auto_in_a_bits_source  = src;
    auto_in_a_bits_address = addr + 32'(8 * k);
    auto_in_a_bits_mask    = t_mask[k];
    auto_in_a_bits_data    = t_data[k];
    auto_in_a_bits_corrupt = t_corrupt[k];
    while (!auto_in_a_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!auto_in_a_ready) check("a_ready_timeout", 64'(auto_in_a_ready), 64'd1);
    @(negedge clock);
  endtask

  task automatic check_d(input logic [2:0] op, input logic [3:0] size, input logic src,
                         input logic den, input logic cor, input logic [63:0] data);
    check("d_opcode",  64'(auto_in_d_bits_opcode),  64'(op));
    check("d_size",    64'(auto_in_d_bits_size),    64'(size));
    check("d_source",  64'(auto_in_d_bits_source),  64'(src));
    check("d_denied",  64'(auto_in_d_bits_denied),  64'(den));
    check("d_corrupt", 64'(auto_in_d_bits_corrupt), 64'(cor));
    check("d_data",    auto_in_d_bits_data,         data);
    check("d_param_sink", 64'({auto_in_d_bits_param, auto_in_d_bits_sink}), 64'd0);
  endtask

  // Waits for a D beat, holds it for 'stall' cycles checking it stays put, then accepts it.
  task automatic recv_d(input logic [2:0] op, input logic [3:0] size, input logic src,
                        input logic den, input logic cor, input logic [63:0] data, input int stall);
    int n = 0;
    auto_in_d_ready = 1'b0;
    while (!auto_in_d_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("d_valid", 64'(auto_in_d_valid), 64'd1);
    for (int s = 0; s < stall; s++) begin
      check_d(op, size, src, den, cor, data);
      @(negedge clock);
      check("d_valid_stall", 64'(auto_in_d_valid), 64'd1);
    end
    check_d(op, size, src, den, cor, data);
    auto_in_d_ready = 1'b1;
    @(negedge clock);
    auto_in_d_ready = 1'b0;
  endtask

  // One complete transaction checked against the model. stall_mode: 0 none, 1 alternate, 2 random.
  task automatic txn(input logic [2:0] op, input logic [3:0] size, input logic [31:0] addr,
                     input logic src, input int stall_mode);
    bit          is_get = (op == 3'd4);
    bit          is_put = (op == 3'd0 || op == 3'd1);
    bit          hit    = (addr >= BASE) && (addr < BASE + 32'(DEPTH * 8));
    int unsigned beats  = (size < 4'd3) ? 1 : (1 << (int'(size) - 3));
    int unsigned idx0   = ((addr - BASE) >> 3) % DEPTH;
    int          stall;
    if (!(is_get || is_put) || size > 4'd6) begin
      logic [2:0] rop = (op >= 3'd2 && op <= 3'd4) ? 3'd1 : 3'd0;
      send_a(op, size, src, addr, 0);
      auto_in_a_valid = 1'b0;
      recv_d(rop, size, src, 1'b1, rop == 3'd1, 64'd0, (stall_mode == 2) ? $urandom_range(0, 2) : 0);
    end else if (is_put) begin
      for (int unsigned k = 0; k < beats; k++) begin
        send_a(op, size, src, addr, int'(k));
        if (hit && !t_corrupt[k]) begin
          for (int b = 0; b < 8; b++)
            if (t_mask[k][b]) model[(idx0 + k) % DEPTH][b*8 +: 8] = t_data[k][b*8 +: 8];
        end
        if (stall_mode == 2 && $urandom_range(0, 3) == 0) begin
          auto_in_a_valid = 1'b0;
          @(negedge clock);
        end
      end
      auto_in_a_valid = 1'b0;
      recv_d(3'd0, size, src, !hit, 1'b0, 64'd0, (stall_mode == 2) ? $urandom_range(0, 2) : 0);
    end else begin
      send_a(op, size, src, addr, 0);
      auto_in_a_valid = 1'b0;
      for (int unsigned k = 0; k < beats; k++) begin
        stall = (stall_mode == 1) ? int'(k % 2) : (stall_mode == 2) ? $urandom_range(0, 2) : 0;
        recv_d(3'd1, size, src, !hit, !hit, hit ? model[(idx0 + k) % DEPTH] : 64'd0, stall);
      end
    end
    check("d_idle_after", 64'(auto_in_d_valid), 64'd0);
    check("a_ready_after", 64'(auto_in_a_ready), 64'd1);
  endtask

  task automatic fill_beats(input logic [7:0] mask);
    for (int k = 0; k < 8; k++) begin
      t_data[k]    = {$urandom, $urandom};
      t_mask[k]    = mask;
      t_corrupt[k] = 1'b0;
    end
  endtask

  initial begin
    logic [2:0]  op;
    logic [3:0]  size;
    logic [31:0] addr;
    int          sel;

    reset = 1'b0;
    auto_in_a_valid = 1'b0;
    auto_in_d_ready = 1'b0;
    auto_in_a_bits_opcode = '0; auto_in_a_bits_param = '0; auto_in_a_bits_size = '0;
    auto_in_a_bits_source = '0; auto_in_a_bits_address = '0; auto_in_a_bits_mask = '0;
    auto_in_a_bits_data = '0; auto_in_a_bits_corrupt = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_a_ready", 64'(auto_in_a_ready), 64'd0);
    check("rst_d_valid", 64'(auto_in_d_valid), 64'd0);
    check("rst_d_bits", {auto_in_d_bits_data[31:0], 16'(auto_in_d_bits_opcode),
                         8'(auto_in_d_bits_size), 4'(auto_in_d_bits_denied),
                         4'(auto_in_d_bits_corrupt)}, 64'd0);
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_a_ready", 64'(auto_in_a_ready), 64'd1);

    // Give every RAM word a known value.
    for (int blk = 0; blk < DEPTH / 8; blk++) begin
      fill_beats(8'hFF);
      txn(3'd0, 4'd6, BASE + 32'(blk * 64), 1'b0, 0);
    end

    // Directed: full then partial 8-byte write and read-back.
    t_data[0] = 64'h1122334455667788; t_mask[0] = 8'hFF; t_corrupt[0] = 1'b0;
    txn(3'd0, 4'd3, BASE, 1'b1, 0);
    txn(3'd4, 4'd3, BASE, 1'b1, 0);
    t_data[0] = 64'hFFFF_FFFF_AAAA_AAAA; t_mask[0] = 8'h0F;
    txn(3'd1, 4'd3, BASE, 1'b0, 0);
    txn(3'd4, 4'd3, BASE, 1'b0, 0);

    // 8-beat burst with data = beat number, read back with d_ready toggling.
    for (int k = 0; k < 8; k++) begin
      t_data[k] = 64'(k); t_mask[k] = 8'hFF; t_corrupt[k] = 1'b0;
    end
    txn(3'd0, 4'd6, BASE + 32'h40, 1'b0, 0);
    txn(3'd4, 4'd6, BASE + 32'h40, 1'b1, 1);

    // Out-of-range and unsupported requests.
    txn(3'd4, 4'd3, 32'h7FFF_FFF8, 1'b0, 0);
    txn(3'd4, 4'd3, BASE + 32'd4096, 1'b1, 0);
    fill_beats(8'hFF);
    txn(3'd0, 4'd3, BASE + 32'd4096, 1'b0, 0);
    txn(3'd2, 4'd3, BASE, 1'b1, 0);
    txn(3'd4, 4'd7, BASE, 1'b0, 0);
    txn(3'd4, 4'd3, BASE, 1'b0, 0);

    // Reset while beat 3 of an 8-beat Get is on D.
    send_a(3'd4, 4'd6, 1'b0, BASE + 32'h40, 0);
    auto_in_a_valid = 1'b0;
    for (int k = 0; k < 3; k++)
      recv_d(3'd1, 4'd6, 1'b0, 1'b0, 1'b0, model[8 + k], 0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("midrst_d_valid", 64'(auto_in_d_valid), 64'd0);
    check("midrst_a_ready", 64'(auto_in_a_ready), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rel_a_ready", 64'(auto_in_a_ready), 64'd1);
    txn(3'd4, 4'd6, BASE + 32'h40, 1'b1, 0);

    // Random traffic.
    for (int t = 0; t < 200; t++) begin
      sel = $urandom_range(0, 15);
      if (sel < 6)       op = 3'd4;
      else if (sel < 10) op = 3'd0;
      else if (sel < 13) op = 3'd1;
      else               op = 3'($urandom_range(2, 7)) == 3'd4 ? 3'd5 : 3'($urandom_range(2, 7));
      size = ($urandom_range(0, 9) == 0) ? 4'd7 : 4'($urandom_range(0, 6));
      sel = $urandom_range(0, 7);
      if (sel == 0)      addr = BASE - 32'(64 * $urandom_range(1, 4));
      else if (sel == 1) addr = BASE + 32'd4096 + 32'(64 * $urandom_range(0, 4));
      else               addr = BASE + 32'($urandom_range(0, 4095));
      addr = addr & ~(32'((1 << int'(size)) - 1));
      for (int k = 0; k < 8; k++) begin
        t_data[k]    = {$urandom, $urandom};
        t_mask[k]    = (op == 3'd0 && size >= 4'd3) ? 8'hFF : 8'($urandom_range(0, 255));
        t_corrupt[k] = ($urandom_range(0, 7) == 0);
      end
      txn(op, size, addr, 1'($urandom_range(0, 1)), 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
